// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch/decode pipeline register.
// State encoding, default payload width and an occupancy helper.
package pipe_pkg;

  localparam int DEFAULT_INSTR_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // Encoding doubles as the entry count.
  function automatic logic [1:0] occ_of(
    input pipe_state_e s
  );
    return s;
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enable payload register, async active-low reset to zero.
// Ports: clk, rstn, i_load (capture enable), i_d (next value), o_q (held value).
module pipe_data_reg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_pipe_reg.sv
// Fetch->decode stage register: valid/ready, optional skid entry, flush.
// Ports: clk, rstn, flush, in_valid/in_data/in_ready (fetch side),
// out_valid/out_data/out_ready (decode side), occupancy (entries held).
module fetch_decode_pipe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_INSTR_WIDTH,
  parameter bit SKID  = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_main_ld;
  logic [WIDTH-1:0] w_main_d;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  pipe_data_reg #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_main_ld),
    .i_d    (w_main_d),
    .o_q    (out_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_state_e      r_state;
      logic             w_skid_ld;
      logic [WIDTH-1:0] w_skid_q;

      pipe_data_reg #(
        .WIDTH (WIDTH)
      ) u_skid (
        .clk    (clk),
        .rstn   (rstn),
        .i_load (w_skid_ld),
        .i_d    (in_data),
        .o_q    (w_skid_q)
      );

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_state <= ST_EMPTY;
        end else if (flush) begin
          r_state <= ST_EMPTY;
        end else begin
          unique case (r_state)
            ST_EMPTY: begin
              if (w_in_fire) r_state <= ST_ONE;
            end
            ST_ONE: begin
              if (w_in_fire && !w_out_fire)
                r_state <= ST_FULL;
              else if (!w_in_fire && w_out_fire)
                r_state <= ST_EMPTY;
            end
            ST_FULL: begin
              if (w_out_fire) r_state <= ST_ONE;
            end
            default: r_state <= ST_EMPTY;
          endcase
        end
      end

      // Flush blocks every load so held data is untouched.
      always_comb begin
        w_main_ld = 1'b0;
        w_main_d  = in_data;
        w_skid_ld = 1'b0;
        if (!flush) begin
          unique case (1'b1)
            (r_state == ST_FULL): begin
              w_main_ld = w_out_fire;
              w_main_d  = w_skid_q;
            end
            (r_state == ST_ONE): begin
              w_main_ld = w_in_fire & w_out_fire;
              w_skid_ld = w_in_fire & !w_out_fire;
            end
            default: begin
              w_main_ld = w_in_fire;
            end
          endcase
        end
      end

      assign in_ready  = (r_state != ST_FULL);
      assign out_valid = (r_state != ST_EMPTY);
      assign occupancy = occ_of(r_state);
    end else begin : g_single
      logic r_valid;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_valid <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_valid <= 1'b1;
        end else if (w_out_fire) begin
          r_valid <= 1'b0;
        end
      end

      assign w_main_ld = w_in_fire & !flush;
      assign w_main_d  = in_data;
      assign in_ready  = !r_valid | out_ready;
      assign out_valid = r_valid;
      assign occupancy = {1'b0, r_valid};
    end
  endgenerate

endmodule

// File: tb/tb_fetch_decode_pipe_reg.sv
// Directed vector bench for fetch_decode_pipe_reg.
// Drives a SKID=1 and a SKID=0 instance from per-cycle vector tables.
module tb_fetch_decode_pipe_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;

  logic         f1, iv1, or1, ir1, ov1;
  logic [W-1:0] id1, od1;
  logic [1:0]   oc1;

  logic         f0, iv0, or0, ir0, ov0;
  logic [W-1:0] id0, od0;
  logic [1:0]   oc0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_decode_pipe_reg #(
    .WIDTH (W),
    .SKID  (1'b1)
  ) u_dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (f1),
    .in_valid  (iv1),
    .in_data   (id1),
    .in_ready  (ir1),
    .out_valid (ov1),
    .out_data  (od1),
    .out_ready (or1),
    .occupancy (oc1)
  );

  fetch_decode_pipe_reg #(
    .WIDTH (W),
    .SKID  (1'b0)
  ) u_dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (f0),
    .in_valid  (iv0),
    .in_data   (id0),
    .in_ready  (ir0),
    .out_valid (ov0),
    .out_data  (od0),
    .out_ready (or0),
    .occupancy (oc0)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_ir;
    logic [1:0]   e_oc;
  } vec_t;

  vec_t t1[$];
  vec_t t0[$];

  function automatic vec_t mk(
    input logic         iv,
    input logic [W-1:0] id,
    input logic         ordy,
    input logic         fl,
    input logic         e_ov,
    input logic [W-1:0] e_od,
    input logic         e_ir,
    input logic [1:0]   e_oc
  );
    vec_t v;
    v.iv   = iv;
    v.id   = id;
    v.ordy = ordy;
    v.fl   = fl;
    v.e_ov = e_ov;
    v.e_od = e_od;
    v.e_ir = e_ir;
    v.e_oc = e_oc;
    return v;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic run1(input int k, input vec_t v);
    iv1 = v.iv;
    id1 = v.id;
    or1 = v.ordy;
    f1  = v.fl;
    @(negedge clk);
    chk($sformatf("s1[%0d].ov", k), 32'(ov1), 32'(v.e_ov));
    chk($sformatf("s1[%0d].od", k), od1, v.e_od);
    chk($sformatf("s1[%0d].ir", k), 32'(ir1), 32'(v.e_ir));
    chk($sformatf("s1[%0d].occ", k), 32'(oc1), 32'(v.e_oc));
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input int k, input vec_t v);
    iv0 = v.iv;
    id0 = v.id;
    or0 = v.ordy;
    f0  = v.fl;
    @(negedge clk);
    chk($sformatf("s0[%0d].ov", k), 32'(ov0), 32'(v.e_ov));
    chk($sformatf("s0[%0d].od", k), od0, v.e_od);
    chk($sformatf("s0[%0d].ir", k), 32'(ir0), 32'(v.e_ir));
    chk($sformatf("s0[%0d].occ", k), 32'(oc0), 32'(v.e_oc));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // SKID=1: stream 1..8, then skid, hold, flush scenarios.
    t1.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0));
    for (int i = 2; i <= 8; i++)
      t1.push_back(mk(1, W'(i), 1, 0, 1, W'(i - 1), 1, 1));
    t1.push_back(mk(0, 0, 1, 0, 1, 8, 1, 1));
    t1.push_back(mk(0, 0, 1, 0, 0, 8, 1, 0));
    t1.push_back(mk(1, 'h11, 1, 0, 0, 8, 1, 0));
    t1.push_back(mk(1, 'h22, 0, 0, 1, 'h11, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 1, 'h11, 0, 2));
    t1.push_back(mk(0, 0, 1, 0, 1, 'h11, 0, 2));
    t1.push_back(mk(0, 0, 1, 0, 1, 'h22, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 0, 'h22, 1, 0));
    t1.push_back(mk(1, 'h44, 0, 0, 0, 'h22, 1, 0));
    for (int i = 0; i < 5; i++)
      t1.push_back(mk(0, 0, 0, 0, 1, 'h44, 1, 1));
    t1.push_back(mk(1, 'h55, 0, 0, 1, 'h44, 1, 1));
    t1.push_back(mk(1, 'h33, 0, 1, 1, 'h44, 0, 2));
    t1.push_back(mk(0, 0, 1, 0, 0, 'h44, 1, 0));
    t1.push_back(mk(1, 'h66, 1, 0, 0, 'h44, 1, 0));
    t1.push_back(mk(1, 'h33, 0, 1, 1, 'h66, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 0, 'h66, 1, 0));
    t1.push_back(mk(1, 'h77, 0, 0, 0, 'h66, 1, 0));
    t1.push_back(mk(1, 'h88, 0, 0, 1, 'h77, 1, 1));
    t1.push_back(mk(0, 0, 0, 0, 1, 'h77, 0, 2));

    // SKID=0: pass-through ready, concurrent fire, flush drop.
    t0.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0));
    t0.push_back(mk(1, 2, 0, 0, 1, 1, 0, 1));
    t0.push_back(mk(1, 2, 1, 0, 1, 1, 1, 1));
    t0.push_back(mk(0, 0, 0, 0, 1, 2, 0, 1));
    t0.push_back(mk(0, 0, 1, 0, 1, 2, 1, 1));
    t0.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
    t0.push_back(mk(1, 3, 0, 1, 0, 2, 1, 0));
    t0.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
    t0.push_back(mk(1, 9, 0, 0, 0, 2, 1, 0));
    t0.push_back(mk(0, 0, 0, 1, 1, 9, 0, 1));
    t0.push_back(mk(0, 0, 0, 0, 0, 9, 1, 0));

    rstn = 1'b0;
    {f1, iv1, or1, id1} = '0;
    {f0, iv0, or0, id0} = '0;
    #12;
    chk("rst.ov1", 32'(ov1), 0);
    chk("rst.od1", od1, 0);
    chk("rst.ir1", 32'(ir1), 1);
    chk("rst.oc1", 32'(oc1), 0);
    chk("rst.ov0", 32'(ov0), 0);
    chk("rst.ir0", 32'(ir0), 1);
    chk("rst.oc0", 32'(oc0), 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (t1[k]) run1(k, t1[k]);

    // Still FULL here; async reset between edges.
    #1;
    rstn = 1'b0;
    #1;
    chk("arst.ov1", 32'(ov1), 0);
    chk("arst.od1", od1, 0);
    chk("arst.oc1", 32'(oc1), 0);
    chk("arst.ir1", 32'(ir1), 1);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run1(100, mk(0, 0, 1, 0, 0, 0, 1, 0));

    foreach (t0[k]) run0(k, t0[k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
